// File: rtl/grid_painter_pkg.sv
// rtl/grid_painter_pkg.sv - shared grid/VGA geometry constants and the painter state type
package grid_painter_pkg;

  localparam int GRID_W   = 64;
  localparam int GRID_H   = 32;
  localparam int GRID_X_W = 6;
  localparam int GRID_Y_W = 5;
  localparam int COLOUR_W = 3;
  localparam int VGA_X_W  = 8;
  localparam int VGA_Y_W  = 7;
  localparam int VGA_MAX_X = 160;
  localparam int VGA_MAX_Y = 120;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_PAINT = 3'd3,
    ST_DONE  = 3'd4
  } painter_state_t;

endpackage

// File: rtl/grid_painter.sv
// rtl/grid_painter.sv - redraws a 64x32 cell grid as CELL_PX x CELL_PX pixel blocks on the VGA adapter
module grid_painter
  import grid_painter_pkg::*;
#(
  parameter int CELL_PX  = 2,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                done,
  output logic [GRID_X_W-1:0] grid_x,
  output logic [GRID_Y_W-1:0] grid_y,
  input  logic [COLOUR_W-1:0] grid_out,
  output logic [VGA_X_W-1:0]  vga_x,
  output logic [VGA_Y_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_write
);

  localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  if ((X_ORIGIN + GRID_W * CELL_PX > VGA_MAX_X) || (Y_ORIGIN + GRID_H * CELL_PX > VGA_MAX_Y)) begin : g_bad_geometry
    $error("grid_painter: grid does not fit on the 160x120 screen");
  end

  painter_state_t        state, state_next;
  logic [GRID_X_W-1:0]   cell_x;
  logic [GRID_Y_W-1:0]   cell_y;
  logic [SUB_W-1:0]      sub_x, sub_y;
  logic [COLOUR_W-1:0]   colour;

  logic sub_x_last, sub_y_last, cell_x_last, cell_y_last;

  assign sub_x_last  = (sub_x == SUB_W'(CELL_PX - 1));
  assign sub_y_last  = (sub_y == SUB_W'(CELL_PX - 1));
  assign cell_x_last = (cell_x == GRID_X_W'(GRID_W - 1));
  assign cell_y_last = (cell_y == GRID_Y_W'(GRID_H - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_READ;
      ST_READ:  state_next = ST_LATCH;
      ST_LATCH: state_next = ST_PAINT;
      ST_PAINT: begin
        if (sub_x_last && sub_y_last)
          state_next = (cell_x_last && cell_y_last) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counters wrap naturally past the last cell, so DONE/IDLE always see (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cell_x <= '0;
      cell_y <= '0;
      sub_x  <= '0;
      sub_y  <= '0;
      colour <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cell_x <= '0;
            cell_y <= '0;
          end
        end
        ST_LATCH: begin
          colour <= grid_out;
          sub_x  <= '0;
          sub_y  <= '0;
        end
        ST_PAINT: begin
          if (sub_x_last) begin
            sub_x <= '0;
            if (sub_y_last) begin
              sub_y  <= '0;
              cell_x <= cell_x + 1'b1;
              if (cell_x_last) cell_y <= cell_y + 1'b1;
            end else begin
              sub_y <= sub_y + 1'b1;
            end
          end else begin
            sub_x <= sub_x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel addresses are formed 10 bits wide and then truncated to the adapter width.
  always_comb begin
    done       = 1'b0;
    grid_x     = '0;
    grid_y     = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_write  = 1'b0;
    case (state)
      ST_READ, ST_LATCH: begin
        grid_x = cell_x;
        grid_y = cell_y;
      end
      ST_PAINT: begin
        grid_x     = cell_x;
        grid_y     = cell_y;
        vga_write  = 1'b1;
        vga_x      = VGA_X_W'(10'(X_ORIGIN) + 10'(cell_x) * 10'(CELL_PX) + 10'(sub_x));
        vga_y      = VGA_Y_W'(10'(Y_ORIGIN) + 10'(cell_y) * 10'(CELL_PX) + 10'(sub_y));
        vga_colour = colour;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_grid_painter.sv
// tb/tb_grid_painter.sv - directed self-checking bench for grid_painter
module tb_grid_painter;
  import grid_painter_pkg::*;

  localparam int CP = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                done;
  logic [GRID_X_W-1:0] grid_x;
  logic [GRID_Y_W-1:0] grid_y;
  logic [COLOUR_W-1:0] grid_out = '0;
  logic [VGA_X_W-1:0]  vga_x;
  logic [VGA_Y_W-1:0]  vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_write;

  grid_painter #(.CELL_PX(CP), .X_ORIGIN(0), .Y_ORIGIN(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .grid_x     (grid_x),
    .grid_y     (grid_y),
    .grid_out   (grid_out),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write)
  );

  always #5 clock = ~clock;

  logic [2:0] mem [0:31][0:63];
  always @(posedge clock) grid_out <= mem[grid_y][grid_x];

  int errors = 0;
  int checks = 0;

  int writes, order_err, colour_err, zero_err, first_cyc, done_cyc, done_cnt, f2_first;
  int w_cyc [8];
  logic [17:0] w_pix [8];
  logic [17:0] last4 [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [2:0] val);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        mem[y][x] = val;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Cycle c=1 is the cycle right after the edge that samples start.
  task automatic run_frame(input bit hold, input int max_c, input int rst_c);
    int n, cx, cy, sx, sy, ex, ey;
    n = 0; order_err = 0; colour_err = 0; zero_err = 0;
    first_cyc = -1; done_cyc = -1; done_cnt = 0; f2_first = -1;
    for (int i = 0; i < 8; i++) begin w_cyc[i] = -1; w_pix[i] = '0; end
    for (int i = 0; i < 4; i++) last4[i] = '0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clock);
      if (c == rst_c) begin
        check("pre_reset_pixel", {vga_write, vga_x, vga_y}, {1'b1, 8'd21, 7'd10});
        reset = 1'b1;
        #1;
        check("reset_vga_write", 32'(vga_write), 32'd0);
        check("reset_outputs", {vga_x, vga_y, vga_colour, grid_x, grid_y, done}, 32'd0);
        writes = n;
        return;
      end
      if (vga_write) begin
        if (done_cnt > 0) begin
          if (f2_first < 0) f2_first = c;
        end else begin
          cx = (n / (CP * CP)) % 64;
          cy = (n / (CP * CP)) / 64;
          sx = n % CP;
          sy = (n / CP) % CP;
          ex = cx * CP + sx;
          ey = cy * CP + sy;
          if (vga_x != 8'(ex) || vga_y != 7'(ey)) order_err++;
          if (grid_x != 6'(cx) || grid_y != 5'(cy)) order_err++;
          if (vga_colour != mem[cy][cx]) colour_err++;
          if (n == 0) first_cyc = c;
          if (n < 8) begin w_cyc[n] = c; w_pix[n] = {vga_x, vga_y, vga_colour}; end
          last4[n % 4] = {vga_x, vga_y, vga_colour};
          n++;
        end
      end else if (vga_x != 0 || vga_y != 0 || vga_colour != 0) begin
        zero_err++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (hold && f2_first >= 0) break;
      if (!hold && done_cyc >= 0 && c >= done_cyc + 1) break;
    end
    writes = n;
  endtask

  initial begin
    fill(3'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_idle_outputs", {vga_x, vga_y, vga_colour, grid_x, grid_y, done, vga_write}, 32'd0);
    reset = 1'b0;

    // full frame, uniform colour
    fill(3'b101);
    run_frame(1'b0, 13000, 0);
    check("full_writes", writes, 8192);
    check("full_order", order_err, 0);
    check("full_colour", colour_err, 0);
    check("full_zero_when_idle", zero_err, 0);
    check("full_first_write_cycle", first_cyc, 3);
    check("full_done_cycle", done_cyc, 12289);
    check("full_done_width", done_cnt, 1);

    // corner cell is the last block painted
    fill(3'd0);
    mem[31][63] = 3'b010;
    run_frame(1'b0, 13000, 0);
    check("corner_colour", colour_err, 0);
    check("corner_last0", last4[0], {8'd126, 7'd62, 3'b010});
    check("corner_last1", last4[1], {8'd127, 7'd62, 3'b010});
    check("corner_last2", last4[2], {8'd126, 7'd63, 3'b010});
    check("corner_last3", last4[3], {8'd127, 7'd63, 3'b010});

    // ordering and per-cell latency at the start of a frame
    fill(3'd0);
    mem[0][1] = 3'b111;
    run_frame(1'b0, 12, 0);
    check("order_first_cycle", w_cyc[0], 3);
    check("order_first_pixel", w_pix[0], {8'd0, 7'd0, 3'b000});
    check("order_second_pixel", w_pix[1], {8'd1, 7'd0, 3'b000});
    check("order_cell1_cycle", w_cyc[4], 9);
    check("order_cell1_pixel", w_pix[4], {8'd2, 7'd0, 3'b111});
    do_reset();

    // held start: one done, then the next frame restarts from IDLE
    fill(3'b101);
    run_frame(1'b1, 12400, 0);
    check("held_frame1_writes", writes, 8192);
    check("held_done_count", done_cnt, 1);
    check("held_frame2_first_write", f2_first, 12293);
    do_reset();

    // reset while painting cell (10,5)
    run_frame(1'b0, 13000, 1984);
    check("midreset_no_done", done_cnt, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done || vga_write) done_cnt++;
    end
    check("midreset_quiet_after", done_cnt, 0);
    run_frame(1'b0, 13000, 0);
    check("restart_first_write_cycle", first_cyc, 3);
    check("restart_first_pixel", w_pix[0], {8'd0, 7'd0, 3'b101});
    check("restart_writes", writes, 8192);
    check("restart_order", order_err, 0);
    check("restart_done_cycle", done_cyc, 12289);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
